// File: rtl/axi_txn_scheduler.sv
// AXI transaction scheduler: arbitrates periodic poll reads and host read/write
// requests onto a single-outstanding AXI master, with completion timeout and
// a timed reset/recovery phase.
module axi_txn_scheduler #(
  parameter int unsigned POLL_PERIOD = 50000,
  parameter logic [31:0] POLL_ADDR   = 32'h0000_00A0,
  parameter int unsigned TIMEOUT     = 4095,
  parameter int unsigned RST_HOLD    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_enable,
  input  logic        i_rd_req,
  input  logic [31:0] i_rd_addr,
  input  logic        i_wr_req,
  input  logic [31:0] i_wr_addr,
  input  logic [63:0] i_wr_data,
  output logic        o_rd_ack,
  output logic        o_wr_ack,
  output logic        o_initreadtxn,
  output logic        o_initwritetxn,
  output logic [31:0] o_readAdress,
  output logic [31:0] o_write_address,
  output logic [63:0] o_write_payload,
  input  logic        i_read_TxnDone,
  input  logic        i_write_TxnDone,
  output logic        o_axi_reset,
  output logic        o_busy,
  output logic        o_timeout_err,
  output logic        o_poll_done
);

  localparam int unsigned PollW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam int unsigned ToW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned RecW  = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StRdIssue,
    StRdWait,
    StWrIssue,
    StWrWait,
    StRecover
  } state_e;

  state_e state_q, state_d;

  logic [PollW-1:0] poll_cnt_q, poll_cnt_d;
  logic             poll_pend_q, poll_pend_d;
  logic             poll_wrap;
  // 1: write wins the next read/write tie, 0: read wins
  logic             rr_wr_q, rr_wr_d;
  logic [ToW-1:0]   to_cnt_q, to_cnt_d;
  logic [ToW-1:0]   to_cnt_inc;
  logic [RecW-1:0]  rec_cnt_q, rec_cnt_d;
  logic             is_poll_q, is_poll_d;

  logic [31:0] rd_addr_q, rd_addr_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [63:0] wr_data_q, wr_data_d;
  logic        rd_ack_q, rd_ack_d;
  logic        wr_ack_q, wr_ack_d;
  logic        init_rd_q, init_rd_d;
  logic        init_wr_q, init_wr_d;
  logic        poll_done_q, poll_done_d;
  logic        to_err_q, to_err_d;

  logic grant_poll, grant_rd, grant_wr;

  // Free-running poll timer; runs in every FSM state while enabled.
  always_comb begin
    poll_cnt_d = poll_cnt_q;
    poll_wrap  = 1'b0;
    if (!i_enable) begin
      poll_cnt_d = '0;
    end else if (poll_cnt_q == PollW'(POLL_PERIOD - 1)) begin
      poll_cnt_d = '0;
      poll_wrap  = 1'b1;
    end else begin
      poll_cnt_d = poll_cnt_q + 1'b1;
    end
  end

  // Arbitration in IDLE: pending poll first, then round-robin between host requests.
  always_comb begin
    grant_poll = 1'b0;
    grant_rd   = 1'b0;
    grant_wr   = 1'b0;
    if (state_q == StIdle) begin
      if (poll_pend_q) begin
        grant_poll = 1'b1;
      end else begin
        grant_rd = i_rd_req && (!i_wr_req || !rr_wr_q);
        grant_wr = i_wr_req && (!i_rd_req || rr_wr_q);
      end
    end
  end

  // Poll pending flag: a wrap sets it (no queueing), a poll grant clears it.
  always_comb begin
    poll_pend_d = poll_pend_q;
    if (!i_enable) begin
      poll_pend_d = 1'b0;
    end else if (poll_wrap) begin
      poll_pend_d = 1'b1;
    end else if (grant_poll) begin
      poll_pend_d = 1'b0;
    end
  end

  assign to_cnt_inc = to_cnt_q + 1'b1;

  // Main FSM next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    rr_wr_d     = rr_wr_q;
    to_cnt_d    = to_cnt_q;
    rec_cnt_d   = rec_cnt_q;
    is_poll_d   = is_poll_q;
    rd_addr_d   = rd_addr_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    to_err_d    = to_err_q;
    rd_ack_d    = 1'b0;
    wr_ack_d    = 1'b0;
    init_rd_d   = 1'b0;
    init_wr_d   = 1'b0;
    poll_done_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (grant_poll) begin
          // Poll grants leave the round-robin pointer untouched
          state_d   = StRdIssue;
          is_poll_d = 1'b1;
          rd_addr_d = POLL_ADDR;
          init_rd_d = 1'b1;
        end else if (grant_rd) begin
          state_d   = StRdIssue;
          is_poll_d = 1'b0;
          rd_addr_d = i_rd_addr;
          init_rd_d = 1'b1;
          rd_ack_d  = 1'b1;
          rr_wr_d   = 1'b1;
        end else if (grant_wr) begin
          state_d   = StWrIssue;
          is_poll_d = 1'b0;
          wr_addr_d = i_wr_addr;
          wr_data_d = i_wr_data;
          init_wr_d = 1'b1;
          wr_ack_d  = 1'b1;
          rr_wr_d   = 1'b0;
        end
      end

      StRdIssue: begin
        state_d  = StRdWait;
        to_cnt_d = '0;
      end

      StWrIssue: begin
        state_d  = StWrWait;
        to_cnt_d = '0;
      end

      StRdWait: begin
        // Done is checked before the timeout so a same-cycle done wins
        if (i_read_TxnDone) begin
          state_d     = StIdle;
          poll_done_d = is_poll_q;
        end else if (to_cnt_inc == ToW'(TIMEOUT)) begin
          state_d   = StRecover;
          rec_cnt_d = '0;
          to_err_d  = 1'b1;
        end else begin
          to_cnt_d = to_cnt_inc;
        end
      end

      StWrWait: begin
        if (i_write_TxnDone) begin
          state_d = StIdle;
        end else if (to_cnt_inc == ToW'(TIMEOUT)) begin
          state_d   = StRecover;
          rec_cnt_d = '0;
          to_err_d  = 1'b1;
        end else begin
          to_cnt_d = to_cnt_inc;
        end
      end

      StRecover: begin
        if (rec_cnt_q == RecW'(RST_HOLD - 1)) begin
          state_d = StIdle;
        end else begin
          rec_cnt_d = rec_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; reset parks the FSM in RECOVER.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRecover;
      poll_cnt_q  <= '0;
      poll_pend_q <= 1'b0;
      rr_wr_q     <= 1'b0;
      to_cnt_q    <= '0;
      rec_cnt_q   <= '0;
      is_poll_q   <= 1'b0;
      rd_addr_q   <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rd_ack_q    <= 1'b0;
      wr_ack_q    <= 1'b0;
      init_rd_q   <= 1'b0;
      init_wr_q   <= 1'b0;
      poll_done_q <= 1'b0;
      to_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      poll_cnt_q  <= poll_cnt_d;
      poll_pend_q <= poll_pend_d;
      rr_wr_q     <= rr_wr_d;
      to_cnt_q    <= to_cnt_d;
      rec_cnt_q   <= rec_cnt_d;
      is_poll_q   <= is_poll_d;
      rd_addr_q   <= rd_addr_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rd_ack_q    <= rd_ack_d;
      wr_ack_q    <= wr_ack_d;
      init_rd_q   <= init_rd_d;
      init_wr_q   <= init_wr_d;
      poll_done_q <= poll_done_d;
      to_err_q    <= to_err_d;
    end
  end

  assign o_rd_ack        = rd_ack_q;
  assign o_wr_ack        = wr_ack_q;
  assign o_initreadtxn   = init_rd_q;
  assign o_initwritetxn  = init_wr_q;
  assign o_readAdress    = rd_addr_q;
  assign o_write_address = wr_addr_q;
  assign o_write_payload = wr_data_q;
  assign o_poll_done     = poll_done_q;
  assign o_timeout_err   = to_err_q;
  // rst forces these immediately so they are correct from the first reset cycle
  assign o_axi_reset     = rst || (state_q == StRecover);
  assign o_busy          = !rst && (state_q != StIdle);

endmodule

// File: tb/tb_axi_txn_scheduler.sv
// Directed bench for axi_txn_scheduler with a transaction scoreboard.
module tb_axi_txn_scheduler;

  localparam logic [31:0] PollAddr = 32'h0000_00A0;
  localparam logic [31:0] RdA1 = 32'h1000_0010;
  localparam logic [31:0] WrA1 = 32'h2000_0020;
  localparam logic [31:0] RdA2 = 32'h1000_0030;
  localparam logic [31:0] RdA3 = 32'h1000_0040;
  localparam logic [31:0] WrA2 = 32'h2000_0050;
  localparam logic [63:0] Pay1 = 64'hDEADBEEF_CAFEF00D;
  localparam logic [63:0] Pay2 = 64'h0123_4567_89AB_CDEF;

  logic        clk, rst, i_enable;
  logic        i_rd_req, i_wr_req;
  logic [31:0] i_rd_addr, i_wr_addr;
  logic [63:0] i_wr_data;
  logic        o_rd_ack, o_wr_ack, o_initreadtxn, o_initwritetxn;
  logic [31:0] o_readAdress, o_write_address;
  logic [63:0] o_write_payload;
  logic        i_read_TxnDone, i_write_TxnDone;
  logic        o_axi_reset, o_busy, o_timeout_err, o_poll_done;

  logic resp_rd, resp_wr, man_rd, man_wr;
  logic resp_en;
  int   resp_dly;
  int   checks, failures;

  typedef struct {
    logic        is_wr;
    logic        is_poll;
    logic [31:0] addr;
    logic [63:0] data;
  } txn_t;

  txn_t sb_q[$];
  txn_t exp_t;

  assign i_read_TxnDone  = resp_rd | man_rd;
  assign i_write_TxnDone = resp_wr | man_wr;

  axi_txn_scheduler #(
    .POLL_PERIOD(8),
    .POLL_ADDR  (PollAddr),
    .TIMEOUT    (10),
    .RST_HOLD   (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_enable       (i_enable),
    .i_rd_req       (i_rd_req),
    .i_rd_addr      (i_rd_addr),
    .i_wr_req       (i_wr_req),
    .i_wr_addr      (i_wr_addr),
    .i_wr_data      (i_wr_data),
    .o_rd_ack       (o_rd_ack),
    .o_wr_ack       (o_wr_ack),
    .o_initreadtxn  (o_initreadtxn),
    .o_initwritetxn (o_initwritetxn),
    .o_readAdress   (o_readAdress),
    .o_write_address(o_write_address),
    .o_write_payload(o_write_payload),
    .i_read_TxnDone (i_read_TxnDone),
    .i_write_TxnDone(i_write_TxnDone),
    .o_axi_reset    (o_axi_reset),
    .o_busy         (o_busy),
    .o_timeout_err  (o_timeout_err),
    .o_poll_done    (o_poll_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic is_wr, input logic is_poll, input logic [31:0] addr,
                      input logic [63:0] data);
    txn_t t;
    t.is_wr   = is_wr;
    t.is_poll = is_poll;
    t.addr    = addr;
    t.data    = data;
    sb_q.push_back(t);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ctl"}, {57'd0, o_busy, o_timeout_err, o_poll_done, o_rd_ack, o_wr_ack,
                        o_initreadtxn, o_initwritetxn}, 64'd0);
    chk({tag, "_addr"}, {o_readAdress, o_write_address}, 64'd0);
    chk({tag, "_data"}, o_write_payload, 64'd0);
    chk({tag, "_axirst"}, {63'd0, o_axi_reset}, 64'd1);
  endtask

  // Waits for an issue pulse, bounded; n = negedges consumed.
  task automatic wait_pulse(input string tag, input int bound, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(o_initreadtxn === 1'b1 || o_initwritetxn === 1'b1) && n < bound);
    chk(tag, {63'd0, (o_initreadtxn === 1'b1 || o_initwritetxn === 1'b1)}, 64'd1);
  endtask

  // Counts consecutive negedges with o_axi_reset high.
  task automatic count_axi_rst(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (o_axi_reset !== 1'b1) break;
      n++;
    end
  endtask

  // AXI master model: returns the matching done resp_dly cycles after each issue.
  initial begin
    logic w;
    resp_rd = 1'b0;
    resp_wr = 1'b0;
    forever begin
      @(negedge clk);
      if (resp_en && (o_initreadtxn === 1'b1 || o_initwritetxn === 1'b1)) begin
        w = o_initwritetxn;
        repeat (resp_dly) @(posedge clk);
        #1;
        if (w) resp_wr = 1'b1;
        else   resp_rd = 1'b1;
        @(posedge clk);
        #1;
        resp_rd = 1'b0;
        resp_wr = 1'b0;
      end
    end
  end

  // Scoreboard: each issue pulse is matched against the oldest expected transaction.
  always @(negedge clk) begin
    if (o_initreadtxn === 1'b1 || o_initwritetxn === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_txn", 64'd0, 64'd1);
      end else begin
        exp_t = sb_q.pop_front();
        chk("txn_is_write", {63'd0, o_initwritetxn}, {63'd0, exp_t.is_wr});
        if (exp_t.is_wr) begin
          chk("txn_wr_addr", {32'd0, o_write_address}, {32'd0, exp_t.addr});
          chk("txn_wr_payload", o_write_payload, exp_t.data);
          chk("txn_wr_ack", {62'd0, o_wr_ack, o_rd_ack}, 64'd2);
        end else begin
          chk("txn_rd_addr", {32'd0, o_readAdress}, {32'd0, exp_t.addr});
          chk("txn_rd_ack", {62'd0, o_wr_ack, o_rd_ack}, {63'd0, !exp_t.is_poll});
        end
      end
    end
  end

  initial begin
    int n, m;
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    i_enable  = 1'b0;
    i_rd_req  = 1'b0;
    i_wr_req  = 1'b0;
    i_rd_addr = '0;
    i_wr_addr = '0;
    i_wr_data = '0;
    man_rd    = 1'b0;
    man_wr    = 1'b0;
    resp_en   = 1'b0;
    resp_dly  = 1;

    // Power-on reset and recovery length
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("init_rst");
    @(posedge clk);
    #1 rst = 1'b0;
    count_axi_rst(n);
    chk("init_recover_len", n, 16);
    chk("init_idle_busy", {63'd0, o_busy}, 64'd0);

    // Periodic polling
    i_enable = 1'b1;
    resp_en  = 1'b1;
    resp_dly = 3;
    repeat (4) push(1'b0, 1'b1, PollAddr, 64'd0);
    for (int p = 0; p < 4; p++) begin
      wait_pulse("poll_pulse", 40, n);
      if (p > 0) chk("poll_gap", 4 + n, 8);
      for (int j = 1; j <= 4; j++) begin
        @(negedge clk);
        chk("poll_done", {63'd0, o_poll_done}, {63'd0, (j == 4)});
        chk("poll_no_rd_ack", {63'd0, o_rd_ack}, 64'd0);
      end
    end
    i_enable = 1'b0;
    resp_en  = 1'b0;

    // Round-robin arbitration with both requests held
    repeat (2) @(negedge clk);
    chk("arb_wpay_pre", o_write_payload, 64'd0);
    push(1'b0, 1'b0, RdA1, 64'd0);
    push(1'b1, 1'b0, WrA1, Pay1);
    push(1'b0, 1'b0, RdA1, 64'd0);
    push(1'b1, 1'b0, WrA1, Pay1);
    resp_en   = 1'b1;
    resp_dly  = 1;
    i_rd_addr = RdA1;
    i_wr_addr = WrA1;
    i_wr_data = Pay1;
    i_rd_req  = 1'b1;
    i_wr_req  = 1'b1;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    i_rd_req = 1'b0;
    i_wr_req = 1'b0;
    chk("arb_drained", sb_q.size(), 0);
    repeat (4) @(negedge clk);
    resp_en = 1'b0;
    chk("arb_idle", {63'd0, o_busy}, 64'd0);
    chk("arb_rd_addr_hold", {32'd0, o_readAdress}, {32'd0, RdA1});
    chk("arb_wr_addr_hold", {32'd0, o_write_address}, {32'd0, WrA1});

    // Stray completions must be ignored
    push(1'b0, 1'b0, RdA2, 64'd0);
    i_rd_addr = RdA2;
    i_rd_req  = 1'b1;
    wait_pulse("stray_pulse", 20, n);
    i_rd_req = 1'b0;
    man_rd   = 1'b1;
    @(negedge clk);
    man_rd = 1'b0;
    man_wr = 1'b1;
    @(negedge clk);
    man_wr = 1'b0;
    chk("stray_busy1", {62'd0, o_busy, o_axi_reset}, 64'd2);
    @(negedge clk);
    chk("stray_busy2", {62'd0, o_busy, o_axi_reset}, 64'd2);
    man_rd = 1'b1;
    @(negedge clk);
    man_rd = 1'b0;
    chk("stray_done_idle", {61'd0, o_busy, o_poll_done, o_timeout_err}, 64'd0);

    // Timeout and recovery
    push(1'b0, 1'b0, RdA3, 64'd0);
    i_rd_addr = RdA3;
    i_rd_req  = 1'b1;
    wait_pulse("to_pulse", 20, n);
    i_rd_req = 1'b0;
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      n++;
      if (o_axi_reset === 1'b1) break;
    end
    chk("to_wait_len", n, 11);
    chk("to_err_set", {62'd0, o_timeout_err, o_busy}, 64'd3);
    count_axi_rst(m);
    chk("to_recover_len", 1 + m, 16);
    chk("to_err_sticky_idle", {62'd0, o_timeout_err, o_busy}, 64'd2);
    repeat (5) @(negedge clk);
    chk("to_no_retry", {62'd0, o_timeout_err, o_busy}, 64'd2);

    // Reset during a write wait
    push(1'b1, 1'b0, WrA2, Pay2);
    i_wr_addr = WrA2;
    i_wr_data = Pay2;
    i_wr_req  = 1'b1;
    wait_pulse("rstw_pulse", 20, n);
    i_wr_req = 1'b0;
    @(negedge clk);
    chk("rstw_in_wait", {62'd0, o_busy, o_axi_reset}, 64'd2);
    @(posedge clk);
    #1 rst = 1'b1;
    n = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (o_axi_reset === 1'b1) n++;
      if (k > 0) chk_reset_vals("mid_rst");
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    count_axi_rst(m);
    chk("mid_rst_len", n + m, 19);
    chk("mid_rst_idle", {62'd0, o_timeout_err, o_busy}, 64'd0);
    i_enable = 1'b1;
    resp_en  = 1'b1;
    resp_dly = 3;
    push(1'b0, 1'b1, PollAddr, 64'd0);
    wait_pulse("post_rst_poll", 30, n);
    repeat (4) @(negedge clk);
    chk("post_rst_poll_done", {63'd0, o_poll_done}, 64'd1);
    i_enable = 1'b0;
    resp_en  = 1'b0;
    repeat (3) @(negedge clk);
    chk("sb_final_empty", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/axi_txn_scheduler.md
AXI_TXN_SCHEDULER -- requirements
Module: axi_txn_scheduler

Interface
REQ-001 Parameter POLL_PERIOD, default 50000: cycles between automatic poll reads of the AMU point window.
REQ-002 Parameter POLL_ADDR, default 32'h000000A0: read address used by poll reads.
REQ-003 Parameter TIMEOUT, default 4095: maximum WAIT cycles before a transaction is abandoned.
REQ-004 Parameter RST_HOLD, default 16: cycles o_axi_reset stays high during recovery.
REQ-005 Port clk, input, 1: single clock; all logic SHALL be on its rising edge.
REQ-006 Port rst, input, 1: synchronous, active-high reset.
REQ-007 Port i_enable, input, 1: enables periodic poll reads.
REQ-008 Ports i_rd_req (1), i_rd_addr (32): input, host read request (level) and address.
REQ-009 Ports i_wr_req (1), i_wr_addr (32), i_wr_data (64): input, host write request (level), address and payload.
REQ-010 Ports o_rd_ack, o_wr_ack: output, 1 each, one-cycle grant pulses.
REQ-011 Ports o_initreadtxn, o_initwritetxn: output, 1 each, one-cycle start pulses to the AXI master.
REQ-012 Ports o_readAdress (32), o_write_address (32), o_write_payload (64): output, registered transaction fields.
REQ-013 Ports i_read_TxnDone, i_write_TxnDone: input, 1 each, AXI master completion strobes.
REQ-014 Ports o_axi_reset (1), o_busy (1), o_timeout_err (1), o_poll_done (1): output, status and control signals.

Function
REQ-015 The FSM SHALL have the states IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT and RECOVER.
REQ-016 While i_enable=1, the poll counter SHALL count 0..POLL_PERIOD-1 and wrap, and each wrap SHALL set poll_pending; the counter SHALL keep running in every FSM state.
REQ-017 While i_enable=0, the poll counter SHALL hold at 0 and poll_pending SHALL be cleared.
REQ-018 A wrap while poll_pending=1 SHALL leave poll_pending at 1; polls do not queue.
REQ-019 In IDLE, the arbitration priority SHALL be: poll_pending first, then round-robin between i_wr_req and i_rd_req.
REQ-020 Round-robin rule: when both host requests are present, the one not served last SHALL win; after reset, the read request wins.
REQ-021 A poll grant SHALL clear poll_pending and SHALL NOT update the round-robin pointer.
REQ-022 A grant in IDLE cycle N SHALL move the FSM to the matching ISSUE state at N+1.
REQ-023 At N+1 the scheduler SHALL: pulse o_initreadtxn or o_initwritetxn for exactly one cycle; make the address (and payload for writes) valid; pulse o_rd_ack or o_wr_ack for a host grant.
REQ-024 A poll grant SHALL drive o_readAdress=POLL_ADDR and SHALL NOT pulse o_rd_ack.
REQ-025 Address and payload outputs SHALL hold their values until the next grant.
REQ-026 The ISSUE state SHALL advance to the matching WAIT state at N+2.
REQ-027 A completion strobe SHALL be honoured only in its matching WAIT state; done in an ISSUE state, or from the other channel, SHALL be ignored.
REQ-028 Matching done in WAIT SHALL move the FSM to IDLE on the next cycle; a poll read completion SHALL pulse o_poll_done for one cycle at the same time.
REQ-029 The WAIT timeout counter SHALL clear on WAIT entry; if it reaches TIMEOUT without done, the FSM SHALL enter RECOVER and set o_timeout_err.
REQ-030 If done arrives in the same cycle the counter reaches TIMEOUT, done SHALL win.
REQ-031 RECOVER SHALL hold o_axi_reset=1 for RST_HOLD cycles, then return to IDLE; a timed-out transaction SHALL NOT be retried.
REQ-032 o_timeout_err SHALL be sticky and SHALL clear only on rst.
REQ-033 A host request still high when the FSM returns to IDLE SHALL be treated as a new request.
REQ-034 o_busy SHALL equal (state != IDLE).

Reset
REQ-035 While rst=1, every output SHALL be 0 except o_axi_reset=1; this includes addresses, payload and o_timeout_err.
REQ-036 While rst=1, the poll counter, poll_pending, the round-robin pointer and the timeout counter SHALL clear.
REQ-037 On the first cycle with rst=0, the FSM SHALL be in RECOVER and hold o_axi_reset=1 for RST_HOLD more cycles.
REQ-038 rst asserted mid-transaction SHALL abandon the transaction; no done SHALL be awaited afterward.

Verification
REQ-039 Poll scenario: POLL_PERIOD=8, i_enable=1, i_read_TxnDone 3 cycles after each pulse -> o_initreadtxn pulses every 8 cycles, o_readAdress=0xA0, o_poll_done follows each done, o_rd_ack stays 0.
REQ-040 Arbitration scenario: i_rd_req and i_wr_req both held, each done returned immediately -> grant order read, write, read, write; payload 0xDEADBEEF_CAFEF00D appears on o_write_payload exactly at each o_wr_ack.
REQ-041 Timeout scenario: TIMEOUT=10, read granted and no done -> RECOVER after 10 WAIT cycles, o_axi_reset high 16 cycles, o_timeout_err=1 until rst.
REQ-042 Stray-done scenario: i_write_TxnDone during RD_WAIT and i_read_TxnDone during RD_ISSUE -> both ignored, FSM stays in RD_WAIT.
REQ-043 Reset scenario: rst pulsed during WR_WAIT -> all outputs return to reset values, o_axi_reset high for rst duration plus 16 cycles, then normal polling resumes.
